// File: rtl/alu_accum_ctrl.sv
// Accumulator ALU with a valid/ready command port and a registered result port.
// One command in flight at a time: IDLE accepts, EXEC computes, RESP holds until consumed.
module alu_accum_ctrl #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_opcode,
    input  logic [BUS_WIDTH-1:0] cmd_operand,
    input  logic                 cmd_carry_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BUS_WIDTH-1:0] res_y,
    output logic                 res_carry,
    output logic                 res_borrow,
    output logic                 res_zero,
    output logic                 res_parity,
    output logic                 res_invalid,
    output logic [BUS_WIDTH-1:0] acc,
    output logic [15:0]          op_count,
    output logic [15:0]          err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic                 r_live;
    logic [3:0]           r_op;
    logic [BUS_WIDTH-1:0] r_b;
    logic                 r_cin;
    logic [BUS_WIDTH-1:0] r_acc;
    logic [BUS_WIDTH-1:0] r_y;
    logic                 r_carry;
    logic                 r_borrow;
    logic                 r_zero;
    logic                 r_parity;
    logic                 r_invalid;
    logic [15:0]          r_opCount;
    logic [15:0]          r_errCount;

    logic                 w_accept;
    logic                 w_handshake;
    logic [BUS_WIDTH-1:0] w_y;
    logic                 w_carry;
    logic                 w_borrow;
    logic                 w_invalid;

    // r_live keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = r_live;
                if (cmd_valid && r_live) w_nextState = EXEC;
            end
            EXEC: w_nextState = RESP;
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_handshake = res_valid && res_ready;

    always_comb begin
        w_y       = '0;
        w_carry   = 1'b0;
        w_borrow  = 1'b0;
        w_invalid = 1'b0;
        case (r_op)
            4'd0: w_y = r_b;
            4'd1: w_y = r_acc + r_b;
            4'd2: {w_carry, w_y} = {1'b0, r_acc} + {1'b0, r_b} + {{BUS_WIDTH{1'b0}}, r_cin};
            4'd3: {w_borrow, w_y} = {1'b0, r_acc} - {1'b0, r_b};
            4'd4: {w_carry, w_y} = {1'b0, r_acc} + {{BUS_WIDTH{1'b0}}, 1'b1};
            4'd5: {w_borrow, w_y} = {1'b0, r_acc} - {{BUS_WIDTH{1'b0}}, 1'b1};
            4'd6: w_y = r_acc & r_b;
            4'd7: w_y = ~r_acc;
            4'd8: w_y = {r_acc[BUS_WIDTH-2:0], r_acc[BUS_WIDTH-1]};
            4'd9: w_y = {r_acc[0], r_acc[BUS_WIDTH-1:1]};
            default: w_invalid = 1'b1;
        endcase
    end

    // Command fields are frozen at acceptance; results and acc commit on the EXEC->RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_acc      <= '0;
            r_y        <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_invalid  <= 1'b0;
            r_opCount  <= '0;
            r_errCount <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= cmd_opcode;
                r_b   <= cmd_operand;
                r_cin <= cmd_carry_in;
            end
            if (r_state == EXEC) begin
                r_y       <= w_y;
                r_carry   <= w_carry;
                r_borrow  <= w_borrow;
                r_zero    <= (w_y == '0);
                r_parity  <= ^w_y;
                r_invalid <= w_invalid;
                if (!w_invalid) r_acc <= w_y;
            end
            if (w_handshake) begin
                if (r_opCount != 16'hFFFF) r_opCount <= r_opCount + 16'd1;
                if (r_invalid && (r_errCount != 16'hFFFF)) r_errCount <= r_errCount + 16'd1;
            end
        end
    end

    assign res_y       = r_y;
    assign res_carry   = r_carry;
    assign res_borrow  = r_borrow;
    assign res_zero    = r_zero;
    assign res_parity  = r_parity;
    assign res_invalid = r_invalid;
    assign acc         = r_acc;
    assign op_count    = r_opCount;
    assign err_count   = r_errCount;

endmodule
